// File: rtl/dpram_rd_stream_pkg.sv
// Shared definitions for the DPRAM read-side streaming engine:
// FSM state encoding and output FIFO sizing.
package dpram_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/dpram_rd_fifo2.sv
// Two-entry FIFO with a registered head: a head register feeding the consumer
// and a skid register that absorbs the word landing while the head is stalled.
module dpram_rd_fifo2
  import dpram_rd_stream_pkg::*;
#(
  parameter int width = 33
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  push,
  input  logic [width-1:0]      push_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [width-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic             skid_vld;
  logic [width-1:0] skid;
  logic             pop;

  assign pop   = valid & ready;
  assign count = {1'b0, valid} + {1'b0, skid_vld};

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      valid    <= 1'b0;
      head     <= '0;
      skid_vld <= 1'b0;
      skid     <= '0;
    end else if (!valid || pop) begin
      // head is free this cycle: the older skid word has priority over the new push
      if (skid_vld) begin
        valid    <= 1'b1;
        head     <= skid;
        skid_vld <= push;
        if (push) skid <= push_data;
      end else begin
        valid <= push;
        if (push) head <= push_data;
      end
    end else if (push) begin
      skid_vld <= 1'b1;
      skid     <= push_data;
    end
  end

endmodule

// File: rtl/dpram_rd_stream.sv
// Streams a (start, count) window of the DPRAM read port onto a valid/ready
// stream with a last marker, one word per clock when the consumer keeps up.
module dpram_rd_stream
  import dpram_rd_stream_pkg::*;
#(
  parameter int widthad = 10,
  parameter int width   = 32
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               cmd_valid_in,
  output logic               cmd_ready_out,
  input  logic [widthad-1:0] cmd_addr_in,
  input  logic [widthad:0]   cmd_len_in,
  output logic [widthad-1:0] rd_addr_out,
  input  logic [width-1:0]   rd_data_in,
  output logic               data_valid_out,
  input  logic               data_ready_in,
  output logic [width-1:0]   data_out,
  output logic               data_last_out,
  output logic               busy_out
);

  localparam logic [widthad:0]   LEN_ONE  = 1;
  localparam logic [widthad-1:0] ADDR_ONE = 1;

  state_e                state;
  logic [widthad:0]      remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [width:0]        fifo_head;
  logic [2:0]            occupancy;
  logic                  pop, credit_ok, issue, last_issue, cmd_fire, drain_done;

  assign pop        = data_valid_out & data_ready_in;
  assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight};
  // a slot freed by this cycle's pop can be refilled by the read issued now
  assign credit_ok  = occupancy <= (3'd1 + {2'b0, pop});
  assign issue      = (state == RUN) && credit_ok;
  assign last_issue = issue && (remaining == LEN_ONE);
  assign cmd_fire   = cmd_valid_in & cmd_ready_out;
  assign drain_done = !inflight && ((fifo_count == '0) || ((fifo_count == 1) && pop));

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= IDLE;
      cmd_ready_out <= 1'b1;
      busy_out      <= 1'b0;
      rd_addr_out   <= '0;
      remaining     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire && (cmd_len_in != '0)) begin
            rd_addr_out   <= cmd_addr_in;
            remaining     <= cmd_len_in;
            state         <= RUN;
            cmd_ready_out <= 1'b0;
            busy_out      <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr_out <= rd_addr_out + ADDR_ONE;
            remaining   <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state         <= IDLE;
            cmd_ready_out <= 1'b1;
            busy_out      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          cmd_ready_out <= 1'b1;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
    end
  end

  dpram_rd_fifo2 #(.width(width + 1)) u_fifo (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .push      (inflight),
    .push_data ({inflight_last, rd_data_in}),
    .ready     (data_ready_in),
    .valid     (data_valid_out),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign data_last_out = fifo_head[width];
  assign data_out      = fifo_head[width-1:0];

endmodule
